// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of two requesters access to a shared, external
// combinational ALU, registers the result and returns it to the winner.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// where both valid and ready are high. Request side: reqk_valid/op/a/b are
// held by the requester until reqk_ready; reqk_ready is a combinational
// grant that only depends on the request valids, the state and last grant.
// Response side: rspk_valid is held with rsp_y/rsp_zero stable until
// rspk_ready; rspk_ready while rspk_valid is low has no effect.
module alu_arbiter #(
    parameter int PRIO_FIXED = 0  // 0 = round-robin, 1 = requester 0 always wins
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [2:0] req0_op,
    input  logic [2:0] req1_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_zero,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_y,
    input  logic       alu_zero,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;  // requester granted most recently (0 or 1)
    logic       winner;      // requester owning the in-flight operation
    logic       pick1;       // arbitration result: 1 selects requester 1
    logic       grant;       // a grant happens this cycle
    logic       rsp_done;    // winner consumes its response this cycle

    // Arbitration: pick the requester that would win if a grant happened now
    always_comb begin
        pick1 = 1'b0;
        if (PRIO_FIXED != 0) begin
            pick1 = !req0_valid && req1_valid;
        end else if (req0_valid && req1_valid) begin
            pick1 = !last_grant;
        end else begin
            pick1 = req1_valid;
        end
    end

    // Grants only in IDLE and never while reset holds the block
    assign grant      = !reset && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = grant && !pick1;
    assign req1_ready = grant && pick1;

    assign rsp0_valid = (state == RESP) && !winner;
    assign rsp1_valid = (state == RESP) && winner;
    assign rsp_done   = winner ? rsp1_ready : rsp0_ready;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Control FSM plus grant bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        winner     <= pick1;
                        last_grant <= pick1;
                        state      <= EXEC;
                    end
                end
                EXEC: state <= RESP;
                RESP: begin
                    if (rsp_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ALU operand registers: loaded only on a grant, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op <= 3'd0;
            alu_a  <= 8'd0;
            alu_b  <= 8'd0;
        end else if (grant) begin
            alu_op <= pick1 ? req1_op : req0_op;
            alu_a  <= pick1 ? req1_a  : req0_a;
            alu_b  <= pick1 ? req1_b  : req0_b;
        end
    end

    // Result capture at the end of the EXEC cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_y    <= 8'd0;
            rsp_zero <= 1'b0;
        end else if (state == EXEC) begin
            rsp_y    <= alu_y;
            rsp_zero <= alu_zero;
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_FIXED, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority with requester 0 highest.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester k presents an operation.
REQ-005 The block SHALL have ports req0_op / req1_op  input  3  ALU operation code: 000 a, 001 ~a, 010 a+b, 011 a-b, 100 a&b, 101 a|b, 110 -a, 111 -b.
REQ-006 The block SHALL have ports req0_a, req0_b / req1_a, req1_b  input  8  operands.
REQ-007 The block SHALL have ports req0_ready / req1_ready  output  1  operation of requester k accepted this cycle.
REQ-008 The block SHALL have ports rsp0_valid / rsp1_valid  output  1  result for requester k available.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready  input  1  requester k consumes the result.
REQ-010 The block SHALL have ports rsp_y  output  8  and rsp_zero  output  1  shared result and zero flag, meaningful only while a rsp_valid is high.
REQ-011 The block SHALL have ports alu_op  output  3, alu_a  output  8, alu_b  output  8, all registered, driving the shared ALU.
REQ-012 The block SHALL have ports alu_y  input  8  and alu_zero  input  1  combinational ALU result and zero flag.
REQ-013 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, EXEC, RESP.
REQ-015 In IDLE with at least one reqk_valid high, the block SHALL select exactly one winner, drive that reqk_ready high combinationally in the same cycle, capture its op/a/b into alu_op/alu_a/alu_b, record the winner, and go to EXEC.
REQ-016 In IDLE with no reqk_valid high, the block SHALL keep both ready outputs low and remain in IDLE.
REQ-017 reqk_ready SHALL never be high outside IDLE, and at most one ready SHALL be high in any cycle.
REQ-018 In round-robin mode with both valid, the winner SHALL be the requester not granted last; with one valid, that requester SHALL win regardless of history.
REQ-019 In fixed-priority mode, requester 0 SHALL win whenever req0_valid is high.
REQ-020 In EXEC, the block SHALL register alu_y into rsp_y and alu_zero into rsp_zero, and go to RESP after one cycle.
REQ-021 In RESP, the block SHALL hold rspk_valid high for the recorded winner only, with rsp_y and rsp_zero stable, until rspk_ready is high.
REQ-022 On a RESP cycle with rspk_ready high, the block SHALL return to IDLE, with rspk_valid low from the next cycle; no new grant SHALL occur in that same cycle.
REQ-023 Latency SHALL be: grant in cycle N, result registered at the end of N+1, rspk_valid high from N+2; with immediate rsp_ready, the next grant is no earlier than N+3.
REQ-024 alu_op, alu_a and alu_b SHALL keep their last captured values outside grant cycles.
REQ-025 rspk_ready while rspk_valid is low SHALL be ignored.
REQ-026 Requesters SHALL hold valid/op/a/b stable until ready; the block SHALL NOT make ready depend on any rsp input.

Reset
REQ-027 While reset is high, the block SHALL be in IDLE, with rsp_y, rsp_zero, alu_op, alu_a, alu_b = 0, all ready/valid/busy outputs = 0, and last-grant = requester 1, so requester 0 wins the first contention.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response delivered.

Verification
REQ-029 The bench SHALL cover single request: req0 op=010, a=0x05, b=0x03 -> req0_ready in cycle N, rsp0_valid from N+2 with rsp_y=0x08, rsp_zero=0.
REQ-030 The bench SHALL cover zero flag: req1 op=011, a=0x22, b=0x22 -> rsp1_valid with rsp_y=0x00, rsp_zero=1; rsp0_valid stays 0.
REQ-031 The bench SHALL cover round-robin: both requesters valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1, the first going to 0 after reset.
REQ-032 The bench SHALL cover fixed priority: with PRIO_FIXED=1 and both valid for 3 transactions -> all 3 grants go to requester 0 and req1_ready stays 0.
REQ-033 The bench SHALL cover backpressure: rsp0_ready low for 5 cycles during RESP -> rsp0_valid, rsp_y and rsp_zero stable, busy=1, both ready outputs 0.
REQ-034 The bench SHALL cover reset mid-operation: reset asserted during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, and the next grant goes to requester 0.
